anode_scan_capture: RTL

ANODE_SCAN_CAPTURE -- requirements
Module: anode_scan_capture

---
 rtl/anode_scan_capture_pkg.sv | 53 +++++
 rtl/anode_stable_filter.sv | 64 ++++++
 rtl/anode_scan_capture.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/anode_scan_capture_pkg.sv
// Shared definitions for the anode scan capture block.
// Latency: n/a (constants, types and a pure classification function).
// Backpressure: n/a.
//
// Contents:
//   DIG1..DIG4, IDLE_LO, IDLE_HI : active-low one-hot anode patterns
//   an_class_t                   : classification of a sampled anode pattern
//   scan_state_t                 : capture FSM states
//   classify_an()                : pattern -> an_class_t
package anode_scan_capture_pkg;

   // Active-low one-hot anode selects; bit0 drives digit 1.
   localparam logic [3:0] DIG1    = 4'b1110;
   localparam logic [3:0] DIG2    = 4'b1101;
   localparam logic [3:0] DIG3    = 4'b1011;
   localparam logic [3:0] DIG4    = 4'b0111;
   localparam logic [3:0] IDLE_LO = 4'b0000;
   localparam logic [3:0] IDLE_HI = 4'b1111;

   // Digit classes are encoded 0..3 so that bits [1:0] give the digit
   // index (digit number minus one) and bit 2 is clear for any digit.
   typedef enum logic [2:0] {
      CLS_DIG1 = 3'd0,
      CLS_DIG2 = 3'd1,
      CLS_DIG3 = 3'd2,
      CLS_DIG4 = 3'd3,
      CLS_IDLE = 3'd4,
      CLS_BAD  = 3'd5
   } an_class_t;

   typedef enum logic {
      ST_SYNC = 1'b0,
      ST_RUN  = 1'b1
   } scan_state_t;

   // Run-length counter width: must hold STABLE_CYCLES+1 for STABLE_CYCLES
   // up to 15, so that the counter can saturate one past the accept point.
   localparam int unsigned STAB_CNT_W = 5;

   function automatic an_class_t classify_an(input logic [3:0] an_pat);
      an_class_t cls;
      case (an_pat)
         DIG1:             cls = CLS_DIG1;
         DIG2:             cls = CLS_DIG2;
         DIG3:             cls = CLS_DIG3;
         DIG4:             cls = CLS_DIG4;
         IDLE_LO, IDLE_HI: cls = CLS_IDLE;
         default:          cls = CLS_BAD;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/anode_stable_filter.sv
// Anode stability filter: classifies the registered anode pattern and flags
// acceptance once it has been seen on STABLE_CYCLES consecutive edges.
// Latency: accept/class are combinational from the registered pattern; backpressure: none.
//
// Ports:
//   clk_dv, reset : block clock, async active-high reset
//   an_q          : registered anode pattern
//   accept        : high for exactly one cycle per appearance of a stable digit
//   first_seen    : current pattern differs from the one sampled on the previous edge
//   an_class      : classification of an_q
module anode_stable_filter
   import anode_scan_capture_pkg::*;
#(
   parameter int STABLE_CYCLES = 1   // legal range 1..15
) (
   input  logic       clk_dv,
   input  logic       reset,
   input  logic [3:0] an_q,
   output logic       accept,
   output logic       first_seen,
   output an_class_t  an_class
);

   localparam logic [STAB_CNT_W-1:0] RUN_ACCEPT = STAB_CNT_W'(STABLE_CYCLES);
   localparam logic [STAB_CNT_W-1:0] RUN_SAT    = STAB_CNT_W'(STABLE_CYCLES + 1);
   localparam logic [STAB_CNT_W-1:0] RUN_ONE    = STAB_CNT_W'(1);

   logic [3:0]            prev_an;
   logic [STAB_CNT_W-1:0] run_cnt;
   logic [STAB_CNT_W-1:0] run_next;
   logic                  is_digit;

   // run_next is the number of consecutive edges on which an_q has held
   // its current value, including this one. It saturates one past the
   // accept point, so a held pattern hits RUN_ACCEPT exactly once.
   always_comb begin
      an_class   = classify_an(an_q);
      is_digit   = (an_class == CLS_DIG1) || (an_class == CLS_DIG2) ||
                   (an_class == CLS_DIG3) || (an_class == CLS_DIG4);
      first_seen = (an_q != prev_an);
      run_next   = RUN_ONE;
      if (!first_seen) begin
         if (run_cnt >= RUN_SAT) begin
            run_next = RUN_SAT;
         end else begin
            run_next = run_cnt + RUN_ONE;
         end
      end
      accept = is_digit && (run_next == RUN_ACCEPT);
   end

   // prev_an resets to the same value as the input register, so the idle
   // bus seen right after reset does not count as a new appearance.
   always_ff @(posedge clk_dv or posedge reset) begin
      if (reset) begin
         prev_an <= IDLE_LO;
         run_cnt <= '0;
      end else begin
         prev_an <= an_q;
         run_cnt <= run_next;
      end
   end

endmodule

// File: rtl/anode_scan_capture.sv
// Captures the four digit values of a scanned 7-seg anode bus into a frame.
// Latency: input register + filter + FSM; frame_valid two edges after first DIG4 (STABLE_CYCLES=1).
// Backpressure: none; the scan bus cannot be stalled, frames are presented as pulses.
//
// Ports:
//   clk_dv, reset       : block clock, async active-high reset
//   an, led_data        : scanned anode select (active-low one-hot) and digit value
//   o1..o4              : last complete frame, digits 1..4 (held between frames)
//   frame_valid         : one-cycle pulse when o1..o4 update
//   seq_err             : one-cycle pulse on a scan-order or pattern violation
//   locked              : high while the FSM is in RUN
//   err_count           : saturating count of seq_err pulses
module anode_scan_capture
   import anode_scan_capture_pkg::*;
#(
   parameter int STABLE_CYCLES = 1,
   parameter int ERR_W         = 8
) (
   input  logic             clk_dv,
   input  logic             reset,
   input  logic [3:0]       an,
   input  logic [3:0]       led_data,
   output logic [3:0]       o1,
   output logic [3:0]       o2,
   output logic [3:0]       o3,
   output logic [3:0]       o4,
   output logic             frame_valid,
   output logic             seq_err,
   output logic             locked,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   logic [3:0]  an_q;
   logic [3:0]  led_q;
   logic        accept;
   logic        first_seen;
   an_class_t   an_class;
   logic [1:0]  dig_idx;
   scan_state_t state;
   logic [1:0]  exp_idx;      // expected digit, stored as digit number minus one
   logic [3:0]  sh1, sh2, sh3;
   logic        err_hit;
   logic        frame_hit;

   // Every decision below is taken on these registered copies.
   always_ff @(posedge clk_dv or posedge reset) begin
      if (reset) begin
         an_q  <= IDLE_LO;
         led_q <= 4'h0;
      end else begin
         an_q  <= an;
         led_q <= led_data;
      end
   end

   anode_stable_filter #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk_dv     (clk_dv),
      .reset      (reset),
      .an_q       (an_q),
      .accept     (accept),
      .first_seen (first_seen),
      .an_class   (an_class)
   );

   assign dig_idx = an_class[1:0];

   // A bad pattern is flagged on its first sample only, so one held glitch
   // costs one error. An out-of-order digit only counts once accepted.
   always_comb begin
      err_hit   = 1'b0;
      frame_hit = 1'b0;
      if (an_class == CLS_BAD) begin
         err_hit = first_seen;
      end else if (accept && (state == ST_RUN)) begin
         if (dig_idx != exp_idx) begin
            err_hit = 1'b1;
         end else if (dig_idx == 2'd3) begin
            frame_hit = 1'b1;
         end
      end
   end

   // Shadows follow every accepted digit regardless of lock state; only a
   // completed in-order frame ever reaches o1..o4, so stale shadow contents
   // from a broken frame are never published. Digit 4 goes straight to o4.
   always_ff @(posedge clk_dv or posedge reset) begin
      if (reset) begin
         sh1 <= 4'h0;
         sh2 <= 4'h0;
         sh3 <= 4'h0;
      end else if (accept) begin
         case (dig_idx)
            2'd0:    sh1 <= led_q;
            2'd1:    sh2 <= led_q;
            2'd2:    sh3 <= led_q;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_dv or posedge reset) begin
      if (reset) begin
         state       <= ST_SYNC;
         exp_idx     <= 2'd0;
         o1          <= 4'h0;
         o2          <= 4'h0;
         o3          <= 4'h0;
         o4          <= 4'h0;
         frame_valid <= 1'b0;
         seq_err     <= 1'b0;
      end else begin
         frame_valid <= frame_hit;
         seq_err     <= err_hit;
         if (frame_hit) begin
            o1 <= sh1;
            o2 <= sh2;
            o3 <= sh3;
            o4 <= led_q;
         end
         if (an_class == CLS_BAD) begin
            state <= ST_SYNC;
         end else if (an_class == CLS_IDLE) begin
            // Blanking while locked means the scan stopped: drop the frame.
            state <= ST_SYNC;
         end else if (accept) begin
            case (state)
               ST_SYNC: begin
                  if (dig_idx == 2'd0) begin
                     state   <= ST_RUN;
                     exp_idx <= 2'd1;
                  end
               end
               default: begin
                  if (dig_idx == exp_idx) begin
                     exp_idx <= exp_idx + 2'd1;   // 3 -> 0 wraps digit 4 back to 1
                  end else if (dig_idx == 2'd0) begin
                     // Out of order, but a digit 1 is a valid frame start.
                     state   <= ST_RUN;
                     exp_idx <= 2'd1;
                  end else begin
                     state <= ST_SYNC;
                  end
               end
            endcase
         end
      end
   end

   assign locked = (state == ST_RUN);

   always_ff @(posedge clk_dv or posedge reset) begin
      if (reset) begin
         err_count <= '0;
      end else if (err_hit && (err_count != ERR_MAX)) begin
         err_count <= err_count + ERR_ONE;
      end
   end

endmodule
